// File: rtl/fd_fetch_buffer_pkg.sv
// Shared constants and helpers for the fetch buffer slice.
// Optional fetch address check enabled by FETCH_EXC_EN.
package fd_fetch_buffer_pkg;

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [31:0] NOP      = 32'h0;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_SIZE  = 16384;

    typedef struct packed {
        logic [4:0]  exccode;
        logic [31:0] pc;
        logic [31:0] instr;
    } fb_entry_t;

    // Misaligned or outside [base, base+bytes) in 33-bit math to avoid wrap.
    function automatic logic addr_bad(
        input logic [31:0] pc,
        input logic [31:0] base,
        input logic [32:0] bytes
    );
        logic [32:0] pc_x;
        logic [32:0] lo_x;
        logic [32:0] hi_x;
        pc_x = {1'b0, pc};
        lo_x = {1'b0, base};
        hi_x = lo_x + bytes;
        return (pc[1:0] != 2'b00) || (pc_x < lo_x) || (pc_x >= hi_x);
    endfunction

endpackage

// File: rtl/fd_fetch_buffer_fifo_core.sv
// Generic in-order register FIFO with push/pop/clear and occupancy.
// Used by fd_fetch_buffer; FETCH_EXC_EN only changes its WIDTH.
module fetch_fifo_core #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            if (do_push && !do_pop)
                cnt_d = cnt_q + (PTR_W+1)'(1);
            else if (!do_push && do_pop)
                cnt_d = cnt_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/fd_fetch_buffer.sv
// Fetch-to-decode instruction queue with PC-enable back-pressure.
// Define FETCH_EXC_EN to tag bad fetch addresses with AdEL.
module fd_fetch_buffer
    import fd_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] INI_ADDR = IM_BASE,
    parameter int          IM_BYTES = IM_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            f_pc,
    input  logic [31:0]            f_instr,
    input  logic                   f_valid,
    output logic                   f_en,
    input  logic                   flush,
    input  logic                   d_ready,
    output logic                   d_valid,
    output logic [31:0]            d_pc,
    output logic [31:0]            d_instr,
    output logic [4:0]             d_exccode,
    output logic [$clog2(DEPTH):0] count
);

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign f_en    = ~full | flush;
    assign push    = f_valid & ~full & ~flush;
    assign d_valid = ~empty;
    assign pop     = d_valid & d_ready;

`ifdef FETCH_EXC_EN
    localparam int W = $bits(fb_entry_t);
    fb_entry_t wr_e;
    fb_entry_t rd_e;
    logic      bad;

    assign bad          = addr_bad(f_pc, INI_ADDR, 33'(IM_BYTES));
    assign wr_e.pc      = f_pc;
    assign wr_e.instr   = bad ? NOP : f_instr;
    assign wr_e.exccode = bad ? EXC_ADEL : EXC_NONE;
    assign d_exccode    = empty ? EXC_NONE : rd_e.exccode;
`else
    localparam int W = 64;
    logic [63:0] wr_e;
    logic [63:0] rd_e;

    assign wr_e      = {f_pc, f_instr};
    assign d_exccode = EXC_NONE;
`endif

    logic [W-1:0] rd_raw;

    fetch_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (wr_e),
        .rdata (rd_raw),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign rd_e = rd_raw;

`ifdef FETCH_EXC_EN
    assign d_pc    = empty ? 32'h0 : rd_e.pc;
    assign d_instr = empty ? NOP : rd_e.instr;
`else
    assign d_pc    = empty ? 32'h0 : rd_e[63:32];
    assign d_instr = empty ? NOP : rd_e[31:0];
`endif

endmodule
